// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit multicycle CPU: widths, opcodes (also the ALU
// opcode encoding), FSM states and instruction field positions.
package cpu4_pkg;

    localparam int DATA_W  = 4;
    localparam int PC_W    = 4;
    localparam int INSTR_W = 12;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_BEQ = 3'b101;
    localparam logic [2:0] OP_BNE = 3'b110;
    localparam logic [2:0] OP_LI  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    // LSB positions of the instruction fields
    localparam int OP_LSB     = 9;
    localparam int RD_LSB     = 7;
    localparam int RS1_LSB    = 5;
    localparam int RS2_LSB    = 3;
    localparam int BR_RS1_LSB = 7;
    localparam int BR_RS2_LSB = 5;
    localparam int IMM_LSB    = 0;

    function automatic logic is_branch(input logic [2:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/cpu4_regfile.sv
// 4x4-bit register file: two combinational read ports, a debug read port and
// one synchronous write port; synchronous reset clears every register.
module cpu4_regfile
    import cpu4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ra1,
    input  logic [1:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [1:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rd1      = regs[ra1];
    assign rd2      = regs[ra2];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/cpu4_control.sv
// Multicycle sequencer for the 4-bit CPU: FETCH/DECODE/EXEC/WB per instruction,
// drives the external ALU and halts on a taken branch-to-self.
module cpu4_control
    import cpu4_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    output logic               busy,
    output logic               done,
    input  logic [1:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   res_q;
    logic                zero_q;

    logic [2:0]          dec_op;
    logic                dec_br;
    logic [1:0]          ra1, ra2;
    logic [DATA_W-1:0]   rd1, rd2;
    logic [2:0]          ir_op;
    logic [1:0]          ir_rd;
    logic [3:0]          ir_imm;
    logic                rf_we;
    logic [DATA_W-1:0]   rf_wd;
    logic                unused_ir;

    assign dec_op = imem_data[OP_LSB +: 3];
    assign dec_br = is_branch(dec_op);
    assign ra1    = dec_br ? imem_data[BR_RS1_LSB +: 2] : imem_data[RS1_LSB +: 2];
    assign ra2    = dec_br ? imem_data[BR_RS2_LSB +: 2] : imem_data[RS2_LSB +: 2];

    assign ir_op     = ir[OP_LSB +: 3];
    assign ir_rd     = ir[RD_LSB +: 2];
    assign ir_imm    = ir[IMM_LSB +: 4];
    assign unused_ir = ^ir[6:4];

    assign rf_we     = (state == S_WB) && !is_branch(ir_op);
    assign rf_wd     = (ir_op == OP_LI) ? ir_imm : res_q;
    assign imem_addr = pc;

    cpu4_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (ir_rd),
        .wd       (rf_wd)
    );

    // alu_a/alu_b double as the operand latches: loaded in DECODE, cleared after EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state <= S_FETCH;
                        pc    <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir     <= imem_data;
                    alu_a  <= (dec_op == OP_LI) ? '0 : rd1;
                    alu_b  <= (dec_op == OP_LI) ? '0 : rd2;
                    alu_op <= (dec_op == OP_LI) ? OP_ADD : dec_op;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    res_q  <= alu_result;
                    zero_q <= alu_zero;
                    alu_a  <= '0;
                    alu_b  <= '0;
                    alu_op <= '0;
                    state  <= S_WB;
                end
                S_WB: begin
                    if (is_branch(ir_op) && zero_q) begin
                        if (ir_imm == 4'd0) begin
                            state <= S_HALT;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // modulo-16 add makes the raw 4-bit offset act as sext(off)
                            pc    <= pc + ir_imm;
                            state <= S_FETCH;
                        end
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu4_control.sv
// Self-checking bench for cpu4_control with a behavioural ALU, a synchronous
// 16x12 ROM and an instruction-level reference model of the ISA.
module tb_cpu4_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  imem_addr;
    logic [11:0] imem_data = '0;
    logic [3:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_result;
    logic        alu_zero;
    logic        busy, done;
    logic [1:0]  dbg_sel = '0;
    logic [3:0]  dbg_data;

    int errors = 0;
    int checks = 0;

    logic [11:0] rom [16];
    int          m_reg [4];
    int          m_pc;
    bit          m_halt;
    int          trace [$];

    cpu4_control dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .done       (done),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom[imem_addr];

    // Companion ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = {3'b000, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
        if (alu_op == 3'd5)      alu_zero = (alu_a == alu_b);
        else if (alu_op == 3'd6) alu_zero = (alu_a != alu_b);
        else                     alu_zero = (alu_result == 4'd0);
    end

    function automatic logic [11:0] enc_alu(input int op, input int rd, input int rs1, input int rs2);
        return {3'(op), 2'(rd), 2'(rs1), 2'(rs2), 3'b000};
    endfunction

    function automatic logic [11:0] enc_br(input int op, input int rs1, input int rs2, input int off);
        return {3'(op), 2'(rs1), 2'(rs2), 1'b0, 4'(off)};
    endfunction

    function automatic logic [11:0] enc_li(input int rd, input int imm);
        return {3'b111, 2'(rd), 3'b000, 4'(imm)};
    endfunction

    function automatic int to_signed4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // One instruction at ISA level
    task automatic model_step();
        logic [11:0] w;
        int op, a, b, off;
        w  = rom[m_pc];
        op = int'(w[11:9]);
        if (op == 7) begin
            m_reg[w[8:7]] = int'(w[3:0]);
            m_pc = (m_pc + 1) % 16;
        end else if (op == 5 || op == 6) begin
            a   = m_reg[w[8:7]];
            b   = m_reg[w[6:5]];
            off = to_signed4(int'(w[3:0]));
            if ((op == 5 && a == b) || (op == 6 && a != b)) begin
                if (off == 0) m_halt = 1'b1;
                else          m_pc = (m_pc + off + 16) % 16;
            end else begin
                m_pc = (m_pc + 1) % 16;
            end
        end else begin
            a = m_reg[w[6:5]];
            b = m_reg[w[4:3]];
            case (op)
                0: m_reg[w[8:7]] = (a + b) % 16;
                1: m_reg[w[8:7]] = (a - b + 16) % 16;
                2: m_reg[w[8:7]] = a & b;
                3: m_reg[w[8:7]] = a | b;
                default: m_reg[w[8:7]] = (to_signed4(a) < to_signed4(b)) ? 1 : 0;
            endcase
            m_pc = (m_pc + 1) % 16;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
    endtask

    // Starts the program and follows it instruction by instruction, at most max_instr steps.
    task automatic run_program(input string name, input int max_instr, input bit poke, output bit halted);
        trace.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        m_pc   = 0;
        m_halt = 1'b0;
        for (int n = 0; n < max_instr && !m_halt; n++) begin
            trace.push_back(int'(imem_addr));
            checks++;
            if (imem_addr !== 4'(m_pc)) begin
                errors++;
                $display("FAIL %s fetch_pc n=%0d: got %h expected %h", name, n, imem_addr, 4'(m_pc));
            end
            checks++;
            if ({busy, done, alu_op, alu_a, alu_b} !== {1'b1, 1'b0, 11'b0}) begin
                errors++;
                $display("FAIL %s fetch_status n=%0d: busy=%b done=%b op=%h a=%h b=%h expected busy=1 done=0 alu=0",
                         name, n, busy, done, alu_op, alu_a, alu_b);
            end
            model_step();
            if (poke) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
        halted = m_halt;
        if (halted) begin
            checks++;
            if ({busy, done} !== 2'b01 || imem_addr !== 4'(m_pc)) begin
                errors++;
                $display("FAIL %s halt: busy=%b done=%b pc=%h expected busy=0 done=1 pc=%h",
                         name, busy, done, imem_addr, 4'(m_pc));
            end
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 4'(m_reg[i])) begin
                errors++;
                $display("FAIL %s reg r%0d: got %h expected %h", name, i, dbg_data, 4'(m_reg[i]));
            end
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if ({busy, done, imem_addr, alu_op, alu_a, alu_b} !== 17'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b addr=%h op=%h a=%h b=%h expected all 0",
                     busy, done, imem_addr, alu_op, alu_a, alu_b);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 4'h0) begin
                errors++;
                $display("FAIL reset_reg r%0d: got %h expected 0", i, dbg_data);
            end
        end
    endtask

    task automatic test_straight();
        bit h;
        for (int i = 0; i < 16; i++) rom[i] = enc_br(5, 0, 0, 0);
        rom[0] = enc_li(1, 3);
        rom[1] = enc_li(2, 5);
        rom[2] = enc_alu(0, 3, 1, 2);
        rom[3] = enc_alu(1, 0, 1, 2);
        rom[4] = enc_alu(4, 2, 1, 2);
        rom[5] = enc_br(5, 0, 0, 0);
        run_program("straight", 10, 1'b0, h);
        checks++;
        if (imem_addr !== 4'd5 || done !== 1'b1) begin
            errors++;
            $display("FAIL straight_halt_pc: pc=%h done=%b expected pc=5 done=1", imem_addr, done);
        end
        dbg_sel = 2'd3; #1;
        checks++;
        if (dbg_data !== 4'h8) begin errors++; $display("FAIL straight_r3: got %h expected 8", dbg_data); end
        dbg_sel = 2'd0; #1;
        checks++;
        if (dbg_data !== 4'hE) begin errors++; $display("FAIL straight_r0: got %h expected e", dbg_data); end
        dbg_sel = 2'd2; #1;
        checks++;
        if (dbg_data !== 4'h1) begin errors++; $display("FAIL straight_r2: got %h expected 1", dbg_data); end
        @(negedge clk);
        checks++;
        if (imem_addr !== 4'd5 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL straight_hold: pc=%h done=%b busy=%b expected pc=5 done=1 busy=0", imem_addr, done, busy);
        end
    endtask

    task automatic test_restart();
        bit h;
        for (int i = 0; i < 16; i++) rom[i] = enc_br(5, 0, 0, 0);
        rom[0] = enc_alu(0, 3, 3, 1);
        rom[1] = enc_li(1, 9);
        rom[2] = enc_br(5, 0, 0, 0);
        run_program("restart1", 10, 1'b1, h);
        dbg_sel = 2'd3; #1;
        checks++;
        if (dbg_data !== 4'hB) begin errors++; $display("FAIL restart_r3: got %h expected b", dbg_data); end
        run_program("restart2", 10, 1'b1, h);
        dbg_sel = 2'd3; #1;
        checks++;
        if (dbg_data !== 4'h4) begin errors++; $display("FAIL restart2_r3: got %h expected 4", dbg_data); end
    endtask

    task automatic test_loop();
        bit h;
        int n4, taken;
        for (int i = 0; i < 16; i++) rom[i] = enc_br(5, 0, 0, 0);
        rom[0] = enc_li(1, 0);
        rom[1] = enc_li(2, 1);
        rom[2] = enc_li(3, 4);
        rom[3] = enc_alu(0, 1, 1, 2);
        rom[4] = enc_br(6, 1, 3, 15);
        rom[5] = enc_br(5, 0, 0, 0);
        run_program("loop", 30, 1'b0, h);
        n4 = 0;
        taken = 0;
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i] == 4) begin
                n4++;
                if (i + 1 < trace.size() && trace[i+1] == 3) taken++;
            end
        end
        checks++;
        if (n4 != 4 || taken != 3) begin
            errors++;
            $display("FAIL loop_bne_count: executed=%0d taken=%0d expected executed=4 taken=3", n4, taken);
        end
        dbg_sel = 2'd1; #1;
        checks++;
        if (dbg_data !== 4'h4) begin errors++; $display("FAIL loop_r1: got %h expected 4", dbg_data); end
    endtask

    task automatic test_wrap();
        bit h;
        for (int i = 0; i < 16; i++) rom[i] = enc_alu(3, 0, 0, 0);
        run_program("wrap", 20, 1'b0, h);
        checks++;
        if (trace.size() != 20 || trace[15] != 15 || trace[16] != 0) begin
            errors++;
            $display("FAIL wrap_trace: size=%0d t15=%0d t16=%0d expected 20 15 0",
                     trace.size(), trace[15], trace[16]);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL wrap_status: busy=%b done=%b expected busy=1 done=0", busy, done);
        end
    endtask

    task automatic test_mid_reset();
        bit h;
        do_reset(1);
        for (int i = 0; i < 16; i++) rom[i] = enc_br(5, 0, 0, 0);
        rom[0] = enc_li(1, 3);
        rom[1] = enc_li(2, 5);
        rom[2] = enc_alu(0, 3, 1, 2);
        run_program("midrst", 2, 1'b0, h);
        repeat (2) @(negedge clk);
        checks++;
        if (alu_a !== 4'h3 || alu_b !== 4'h5 || alu_op !== 3'd0) begin
            errors++;
            $display("FAIL midrst_exec: a=%h b=%h op=%h expected a=3 b=5 op=0", alu_a, alu_b, alu_op);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        dbg_sel = 2'd3; #1;
        checks++;
        if (busy !== 1'b0 || imem_addr !== 4'h0 || dbg_data !== 4'h0 || alu_a !== 4'h0) begin
            errors++;
            $display("FAIL midrst_after: busy=%b pc=%h r3=%h a=%h expected all 0", busy, imem_addr, dbg_data, alu_a);
        end
        repeat (2) @(negedge clk);
        dbg_sel = 2'd3; #1;
        checks++;
        if (busy !== 1'b0 || dbg_data !== 4'h0) begin
            errors++;
            $display("FAIL midrst_idle: busy=%b r3=%h expected busy=0 r3=0", busy, dbg_data);
        end
    endtask

    task automatic test_random();
        bit h;
        for (int p = 0; p < 6; p++) begin
            do_reset(1);
            for (int i = 0; i < 16; i++) rom[i] = 12'($urandom_range(0, 4095));
            rom[15] = enc_br(5, 0, 0, 0);
            run_program("random", 30, p[0], h);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = '0;
        test_reset();
        test_straight();
        test_restart();
        test_loop();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu4_control.md
# cpu4_control

Multicycle control and datapath sequencer that sits on the issuing side of the 4-bit ALU/branch unit. It fetches 12-bit instructions from a synchronous instruction ROM and holds a 4x4-bit register file. It drives the ALU operands and opcode, then consumes the ALU result and zero flag to write registers or take branches. Together with the ALU it forms a minimal 4-bit CPU for board-level demos.

## Interface
- No parameters; widths are fixed: data 4, PC 4, instruction 12.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled in IDLE/HALT; begins execution at PC 0.
- imem_addr  out  4  instruction address (always equals PC).
- imem_data  in  12  instruction word, valid one cycle after imem_addr (synchronous ROM).
- alu_a, alu_b  out  4 each  ALU operands.
- alu_op  out  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 beq, 110 bne.
- alu_result  in  4  combinational ALU result.
- alu_zero  in  1  ALU zero/branch-condition flag.
- busy  out  1  high in FETCH/DECODE/EXEC/WB.
- done  out  1  high in HALT.
- dbg_sel  in  2  register index for debug read.
- dbg_data  out  4  combinational read of register dbg_sel.

## Operation
- Instruction fields: op [11:9], then per-op fields:
  - ALU ops 000–100: rd [8:7], rs1 [6:5], rs2 [4:3].
  - Branches 101/110: rs1 [8:7], rs2 [6:5], off [3:0], signed.
  - 111 LI: rd [8:7], imm [3:0].
- Unused bits are ignored.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT. Reset state is IDLE.
- IDLE/HALT -> FETCH when start=1. Entry clears PC to 0; registers are kept.
- FETCH -> DECODE: imem_addr=PC, presented by the ROM.
- DECODE: latch imem_data into IR and read rs1/rs2 into operand latches.
- EXEC: drive alu_a=R[rs1], alu_b=R[rs2], alu_op=op. Capture alu_result and alu_zero at the end of the cycle.
  - For LI the ALU is unused; alu_op is driven 000.
- WB, by op class:
  - ALU ops: R[rd] <= captured result; PC <= PC+1.
  - LI: R[rd] <= imm; PC <= PC+1.
  - Branch: taken when captured zero=1, which covers both beq and bne.
    - Taken: PC <= PC + sext(off).
    - Not taken: PC <= PC+1.
- WB -> FETCH, except a taken branch with off=0 (branch-to-self), which is HALT: WB -> HALT with PC unchanged.
- PC arithmetic is modulo 16: PC 15 + 1 wraps to 0; negative offsets wrap.
- Outside EXEC, alu_a, alu_b and alu_op hold 0.
- All four registers are writable; there is no hardwired zero register.
- Reset values: PC 0, IR 0, all registers 0, busy 0, done 0, imem_addr 0, alu_* 0.

## Timing
- Each instruction takes exactly 4 cycles (FETCH, DECODE, EXEC, WB).
- Start is sampled at edge E. FETCH of instruction n (0-based sequential) begins at edge E+4n.
- done rises in the cycle after the halting WB.
- Register writes take effect at the WB edge. The next instruction's DECODE reads the new value; no forwarding is needed.
- start while busy is ignored.
- rst during any state: at the next edge go to IDLE, clear all state, perform no writeback.
- dbg_data reflects a register write in the cycle after the WB edge.

## Structure
- Package cpu4_pkg holds:
  - opcode constants OP_ADD..OP_LI;
  - the state enum;
  - instruction field bit positions;
  - the widths DATA_W=4, PC_W=4, INSTR_W=12.
- The ALU opcode encoding lives in cpu4_pkg and is shared with the ALU.
- One sub-module, cpu4_regfile: 4x4-bit, two combinational read ports plus a debug read port, one synchronous write port, synchronous reset to 0.
- The FSM, IR, PC and operand latches live in cpu4_control.
- The bench instantiates the existing ALU and a 16x12 ROM model.

## Test plan
- Reset: hold rst for 2 cycles -> busy=0, done=0, imem_addr=0, alu_op=0, all dbg_data reads = 0.
- Straight-line program: LI r1,3; LI r2,5; ADD r3,r1,r2; SUB r0,r1,r2; SLT r2,r1,r2; BEQ r0,r0,0 -> r3=8, r0=0xE, r2=1; done rises 24 cycles after start; PC holds 5.
- Loop: LI r1,0; LI r2,1; LI r3,4; ADD r1,r1,r2; BNE r1,r3,-1; BEQ r0,r0,0 -> r1=4 at halt; the BNE at PC 4 executes 4 times, 3 of them taken.
- PC wrap: ROM filled with OR r0,r0,r0 -> imem_addr steps 15 then 0; busy stays 1; done stays 0.
- Mid-operation reset: assert rst in the EXEC cycle of ADD r3,r1,r2 (r1=3, r2=5) -> next cycle in IDLE, r3=0, PC=0, busy=0.
- Restart and ignored start: after HALT, pulse start -> execution resumes at PC 0 with registers preserved. Asserting start while busy has no effect on PC.
